// File: rtl/vx_gpr_tb_bank_responder.sv
// Bench-side GPR bank responder: byte-enabled shadow register file per bank with
// tagged, 2-deep flow-controlled read response queues and a global uninit-read counter.
module vx_gpr_tb_bank_responder #(
  parameter int unsigned NUM_BANKS = 4,
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned TAG_W     = 4,
  parameter int unsigned ADDR_W    = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_BANKS-1:0]          wr_en,
  input  logic [NUM_BANKS*ADDR_W-1:0]   wr_addr,
  input  logic [NUM_BANKS*DATA_W-1:0]   wr_data,
  input  logic [NUM_BANKS*(DATA_W/8)-1:0] wr_byteen,
  input  logic [NUM_BANKS-1:0]          rd_req_valid,
  output logic [NUM_BANKS-1:0]          rd_req_ready,
  input  logic [NUM_BANKS*ADDR_W-1:0]   rd_req_addr,
  input  logic [NUM_BANKS*TAG_W-1:0]    rd_req_tag,
  output logic [NUM_BANKS-1:0]          rd_rsp_valid,
  input  logic [NUM_BANKS-1:0]          rd_rsp_ready,
  output logic [NUM_BANKS*DATA_W-1:0]   rd_rsp_data,
  output logic [NUM_BANKS*TAG_W-1:0]    rd_rsp_tag,
  output logic [NUM_BANKS-1:0]          rd_rsp_uninit,
  output logic [15:0]                   uninit_rd_count
);

  localparam int unsigned BYTES = DATA_W / 8;

  logic [NUM_BANKS-1:0] accept_uninit;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  written;
    logic [ADDR_W-1:0] waddr, raddr;
    logic [DATA_W-1:0] wdata, wmerge, rdata;
    logic [BYTES-1:0]  wbe;
    logic              hit, rd_uninit, push, pop;

    logic [DATA_W-1:0] q_data [2];
    logic [TAG_W-1:0]  q_tag  [2];
    logic [1:0]        q_uninit;
    logic              rd_ptr, wr_ptr;
    logic [1:0]        count;

    assign waddr = wr_addr[b*ADDR_W +: ADDR_W];
    assign raddr = rd_req_addr[b*ADDR_W +: ADDR_W];
    assign wdata = wr_data[b*DATA_W +: DATA_W];
    assign wbe   = wr_byteen[b*BYTES +: BYTES];

    // Byte-merged value of the entry being written this cycle
    always_comb begin
      wmerge = mem[waddr];
      for (int unsigned i = 0; i < BYTES; i++) begin
        if (wbe[i]) wmerge[i*8 +: 8] = wdata[i*8 +: 8];
      end
    end

    // Write-first bypass when a read is accepted against a same-cycle write
    assign hit       = wr_en[b] && (waddr == raddr);
    assign rdata     = hit ? wmerge : mem[raddr];
    assign rd_uninit = hit ? 1'b0 : ~written[raddr];

    assign rd_rsp_valid[b]  = (count != 2'd0);
    assign pop              = rd_rsp_valid[b] & rd_rsp_ready[b];
    assign rd_req_ready[b]  = (count < 2'd2) || ((count == 2'd2) && pop);
    assign push             = rd_req_valid[b] & rd_req_ready[b];
    assign accept_uninit[b] = push & rd_uninit;

    assign rd_rsp_data[b*DATA_W +: DATA_W] = q_data[rd_ptr];
    assign rd_rsp_tag[b*TAG_W +: TAG_W]    = q_tag[rd_ptr];
    assign rd_rsp_uninit[b]                = q_uninit[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        written <= '0;
      end else if (wr_en[b]) begin
        mem[waddr]     <= wmerge;
        written[waddr] <= 1'b1;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        q_data[0] <= '0;
        q_data[1] <= '0;
        q_tag[0]  <= '0;
        q_tag[1]  <= '0;
        q_uninit  <= '0;
        rd_ptr    <= 1'b0;
        wr_ptr    <= 1'b0;
        count     <= 2'd0;
      end else begin
        if (push) begin
          q_data[wr_ptr]   <= rdata;
          q_tag[wr_ptr]    <= rd_req_tag[b*TAG_W +: TAG_W];
          q_uninit[wr_ptr] <= rd_uninit;
          wr_ptr           <= ~wr_ptr;
        end
        if (pop) rd_ptr <= ~rd_ptr;
        case ({push, pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
    end
  end

  // Saturating sum of uninit accepts across all banks
  logic [16:0] cnt_sum;
  logic [15:0] cnt_next;

  always_comb begin
    cnt_sum = {1'b0, uninit_rd_count};
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      cnt_sum = cnt_sum + 17'(accept_uninit[b]);
    end
    cnt_next = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) uninit_rd_count <= 16'd0;
    else          uninit_rd_count <= cnt_next;
  end

endmodule
